// File: rtl/conv_control_if.sv
// ---------------------------------------------------------------------------
// conv_control_if
//
// Control-side bundle between conv_control and its neighbours: the x and f
// producer streams, the y consumer stream, and the memory/accumulator
// controls that go to the convolution datapath. The data buses (s_data_x,
// s_data_f, m_data_out_y) run straight to the datapath and are not part of
// this bundle.
//
// Modports:
//   master - the controller: takes the valids and the consumer ready,
//            drives the readies, m_valid_y and all datapath controls.
//   slave  - the surroundings (producers, consumer, datapath): the mirror.
//
// Signals:
//   s_valid_x / s_ready_x : x sample stream handshake
//   s_valid_f / s_ready_f : filter tap stream handshake
//   m_valid_y / m_ready_y : y result stream handshake
//   addr_x, wr_en_x       : data memory address / write enable
//   addr_f, wr_en_f       : filter memory address / write enable
//   clear_acc, en_acc     : accumulator clear (dominant) / accumulate
// ---------------------------------------------------------------------------
interface conv_control_if #(
    parameter int LG_DATA_N   = 3,
    parameter int LG_FILTER_N = 2
) ();

    logic                   s_valid_x;
    logic                   s_ready_x;
    logic                   s_valid_f;
    logic                   s_ready_f;
    logic                   m_valid_y;
    logic                   m_ready_y;
    logic [LG_DATA_N-1:0]   addr_x;
    logic                   wr_en_x;
    logic [LG_FILTER_N-1:0] addr_f;
    logic                   wr_en_f;
    logic                   clear_acc;
    logic                   en_acc;

    modport master (
        input  s_valid_x,
        input  s_valid_f,
        input  m_ready_y,
        output s_ready_x,
        output s_ready_f,
        output m_valid_y,
        output addr_x,
        output wr_en_x,
        output addr_f,
        output wr_en_f,
        output clear_acc,
        output en_acc
    );

    modport slave (
        output s_valid_x,
        output s_valid_f,
        output m_ready_y,
        input  s_ready_x,
        input  s_ready_f,
        input  m_valid_y,
        input  addr_x,
        input  wr_en_x,
        input  addr_f,
        input  wr_en_f,
        input  clear_acc,
        input  en_acc
    );

endinterface

// File: rtl/conv_control.sv
// ---------------------------------------------------------------------------
// conv_control
//
// Sequencer for the 1-D convolution datapath. It loads DATA_N samples of x
// and FILTER_N taps of f into the datapath memories over two independent
// valid/ready streams, then for n = 0 .. DATA_N-FILTER_N clears the
// accumulator, walks k = 0 .. FILTER_N-1 with addr_x = n+k and addr_f = k
// while en_acc is high, and finally offers the accumulated y[n] (on the
// datapath's m_data_out_y) to the consumer with m_valid_y. After the last y
// of a frame it returns to loading a fresh x and f.
//
// Ports:
//   clk   : single clock, all state updates on its rising edge
//   reset : synchronous, active-high; aborts any frame in progress
//   bus   : conv_control_if.master - stream handshakes and datapath controls
//
// Parameters:
//   DATA_N, FILTER_N       : frame length and tap count, FILTER_N <= DATA_N,
//                            both powers of two with FILTER_N >= 2
//   LG_DATA_N, LG_FILTER_N : log2 of the above (address widths)
// ---------------------------------------------------------------------------
module conv_control #(
    parameter int DATA_N      = 8,
    parameter int FILTER_N    = 4,
    parameter int LG_DATA_N   = 3,
    parameter int LG_FILTER_N = 2
) (
    input  logic          clk,
    input  logic          reset,
    conv_control_if.master bus
);

    // FSM encoding kept as plain constants for compatibility with the
    // existing netlists that probe the state register.
    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_MAC   = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    localparam logic [LG_DATA_N:0]     XCNT_FULL = (LG_DATA_N+1)'(DATA_N);
    localparam logic [LG_DATA_N:0]     XCNT_LAST = (LG_DATA_N+1)'(DATA_N - 1);
    localparam logic [LG_FILTER_N:0]   FCNT_FULL = (LG_FILTER_N+1)'(FILTER_N);
    localparam logic [LG_FILTER_N:0]   FCNT_LAST = (LG_FILTER_N+1)'(FILTER_N - 1);
    localparam logic [LG_DATA_N-1:0]   N_LAST    = LG_DATA_N'(DATA_N - FILTER_N);
    localparam logic [LG_FILTER_N-1:0] K_LAST    = LG_FILTER_N'(FILTER_N - 1);

    logic [1:0]             state;
    logic [LG_DATA_N:0]     xcnt;   // x samples written this frame, 0..DATA_N
    logic [LG_FILTER_N:0]   fcnt;   // f taps written this frame, 0..FILTER_N
    logic [LG_DATA_N-1:0]   n;      // output index, 0..DATA_N-FILTER_N
    logic [LG_FILTER_N-1:0] k;      // tap index within one MAC pass

    // Combinational control decoded from the state and counters.
    logic                   ready_x;
    logic                   ready_f;
    logic                   wr_x;
    logic                   wr_f;
    logic [LG_DATA_N-1:0]   addr_x_c;
    logic [LG_FILTER_N-1:0] addr_f_c;
    logic                   clear_c;
    logic                   en_c;
    logic                   valid_y;

    logic                   y_hs;
    logic                   x_full_next;
    logic                   f_full_next;
    logic                   load_done;

    // -----------------------------------------------------------------------
    // Output decode
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a
        // latch; this also gives the "all outputs 0 unless active" rule.
        ready_x  = 1'b0;
        ready_f  = 1'b0;
        wr_x     = 1'b0;
        wr_f     = 1'b0;
        addr_x_c = '0;
        addr_f_c = '0;
        clear_c  = 1'b0;
        en_c     = 1'b0;
        valid_y  = 1'b0;

        case (state)
            ST_LOAD: begin
                // Readies depend only on state, counters and reset, never on
                // the valids. Gating with reset keeps a producer from
                // believing a beat was taken while the frame is being
                // aborted.
                ready_x = !reset && (xcnt < XCNT_FULL);
                ready_f = !reset && (fcnt < FCNT_FULL);
                wr_x    = bus.s_valid_x && ready_x;
                wr_f    = bus.s_valid_f && ready_f;
                if (wr_x) begin
                    addr_x_c = xcnt[LG_DATA_N-1:0];
                end
                if (wr_f) begin
                    addr_f_c = fcnt[LG_FILTER_N-1:0];
                end
            end
            ST_CLEAR: begin
                clear_c = 1'b1;
            end
            ST_MAC: begin
                // n + k never exceeds DATA_N-1, so this sum cannot wrap.
                addr_x_c = n + LG_DATA_N'(k);
                addr_f_c = k;
                en_c     = 1'b1;
            end
            ST_OUT: begin
                valid_y = 1'b1;
            end
            default: ;
        endcase
    end

    // A counter is full after this edge if it already is, or if this cycle's
    // beat is its last one. Both full means the final beat lands on this edge
    // and the next cycle can already clear the accumulator.
    assign x_full_next = (xcnt == XCNT_FULL) || (wr_x && (xcnt == XCNT_LAST));
    assign f_full_next = (fcnt == FCNT_FULL) || (wr_f && (fcnt == FCNT_LAST));
    assign load_done   = x_full_next && f_full_next;

    assign y_hs = valid_y && bus.m_ready_y;

    assign bus.s_ready_x = ready_x;
    assign bus.s_ready_f = ready_f;
    assign bus.wr_en_x   = wr_x;
    assign bus.wr_en_f   = wr_f;
    assign bus.addr_x    = addr_x_c;
    assign bus.addr_f    = addr_f_c;
    assign bus.clear_acc = clear_c;
    assign bus.en_acc    = en_c;
    assign bus.m_valid_y = valid_y;

    // -----------------------------------------------------------------------
    // State and counters
    // -----------------------------------------------------------------------
    // NOTE: non-blocking assignments throughout, so every register samples
    // the pre-edge values and the order of the statements below is
    // irrelevant.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: only the control state is reset. The datapath memories
            // are outside this block and keep their contents, which is why
            // the counters restart at 0 and force a complete reload.
            state <= ST_LOAD;
            xcnt  <= '0;
            fcnt  <= '0;
            n     <= '0;
            k     <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (wr_x) begin
                        xcnt <= xcnt + 1'b1;
                    end
                    if (wr_f) begin
                        fcnt <= fcnt + 1'b1;
                    end
                    if (load_done) begin
                        state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    k     <= '0;
                    state <= ST_MAC;
                end
                ST_MAC: begin
                    if (k == K_LAST) begin
                        k     <= '0;
                        state <= ST_OUT;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                ST_OUT: begin
                    // Hold here, with no enables, until the consumer takes
                    // y; the accumulator therefore stays stable under
                    // backpressure.
                    if (y_hs) begin
                        if (n == N_LAST) begin
                            n     <= '0;
                            xcnt  <= '0;
                            fcnt  <= '0;
                            state <= ST_LOAD;
                        end else begin
                            n     <= n + 1'b1;
                            state <= ST_CLEAR;
                        end
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Protocol properties
    // -----------------------------------------------------------------------
    // A presented y is never withdrawn before the consumer takes it.
    a_y_held: assert property (@(posedge clk) disable iff (reset)
        (valid_y && !bus.m_ready_y) |=> valid_y);

    // Clear and accumulate are never requested together.
    a_clear_en_excl: assert property (@(posedge clk) disable iff (reset)
        !(clear_c && en_c));

    // The MAC walk stays inside the data memory.
    a_addr_x_range: assert property (@(posedge clk) disable iff (reset)
        (state == ST_MAC) |->
            (({1'b0, n} + (LG_DATA_N+1)'(k)) <= XCNT_LAST));

endmodule

// File: tb/tb_conv_control.sv
// ---------------------------------------------------------------------------
// tb_conv_control
//
// Directed bench for conv_control. A small behavioural datapath (two
// memories, a signed product and a 21-bit accumulator) sits beside the DUT
// so that y values can be observed; expected values are hand-computed
// constants. Each scenario is one task; all are run from one initial block.
// Inputs change 1 time unit after a rising edge, outputs are sampled there
// or on the falling edge.
// ---------------------------------------------------------------------------
module tb_conv_control;

    localparam int DATA_N      = 8;
    localparam int FILTER_N    = 4;
    localparam int LG_DATA_N   = 3;
    localparam int LG_FILTER_N = 2;
    localparam int NY          = DATA_N - FILTER_N + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    conv_control_if #(.LG_DATA_N(LG_DATA_N), .LG_FILTER_N(LG_FILTER_N)) bus ();

    conv_control #(
        .DATA_N(DATA_N), .FILTER_N(FILTER_N),
        .LG_DATA_N(LG_DATA_N), .LG_FILTER_N(LG_FILTER_N)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // ---------------- behavioural datapath ----------------
    logic signed [7:0]  s_data_x;
    logic signed [7:0]  s_data_f;
    logic signed [7:0]  x_mem [DATA_N];
    logic signed [7:0]  f_mem [FILTER_N];
    logic signed [15:0] prod;
    logic signed [20:0] prod_ext;
    logic signed [20:0] acc;

    assign prod     = 16'(x_mem[bus.addr_x]) * 16'(f_mem[bus.addr_f]);
    assign prod_ext = 21'(prod);

    always @(posedge clk) begin
        if (bus.wr_en_x) x_mem[bus.addr_x] <= s_data_x;
        if (bus.wr_en_f) f_mem[bus.addr_f] <= s_data_f;
        if (bus.clear_acc)   acc <= '0;
        else if (bus.en_acc) acc <= acc + prod_ext;
    end

    // ---------------- bench state ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    logic signed [7:0]  vx [DATA_N];
    logic signed [7:0]  vf [FILTER_N];
    logic signed [20:0] got_y [NY];
    int                 got_t [NY];
    int                 n_got;

    // ---------------- stimulus helpers (no comparisons) ----------------
    // Streams vx and vf concurrently with valids held high until every
    // beat has been accepted. Returns at edge+1 after the final beat.
    task automatic load_both();
        int xi = 0;
        int fi = 0;
        int guard = 0;
        bit hx;
        bit hf;
        while ((xi < DATA_N || fi < FILTER_N) && guard < 4 * DATA_N) begin
            bus.s_valid_x = (xi < DATA_N);
            bus.s_valid_f = (fi < FILTER_N);
            if (xi < DATA_N)   s_data_x = vx[xi];
            if (fi < FILTER_N) s_data_f = vf[fi];
            @(negedge clk);
            hx = bus.s_valid_x && bus.s_ready_x;
            hf = bus.s_valid_f && bus.s_ready_f;
            @(posedge clk); #1;
            if (hx) xi++;
            if (hf) fi++;
            guard++;
        end
        bus.s_valid_x = 1'b0;
        bus.s_valid_f = 1'b0;
    endtask

    // With m_ready_y held high, records each presented y and the cycle (from
    // the call) in which it was presented, until NY results or the budget.
    task automatic collect_frame(input int budget);
        int cyc = 0;
        n_got = 0;
        bus.m_ready_y = 1'b1;
        while (n_got < NY && cyc < budget) begin
            if (bus.m_valid_y) begin
                got_y[n_got] = acc;
                got_t[n_got] = cyc;
                n_got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.m_ready_y = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int cycles);
        cycles = 0;
        while (!bus.m_valid_y && cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        bus.s_valid_x = 1'b1;
        bus.s_valid_f = 1'b1;
        bus.m_ready_y = 1'b0;
        s_data_x = '0;
        s_data_f = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({bus.s_ready_x, bus.s_ready_f, bus.m_valid_y, bus.wr_en_x, bus.wr_en_f,
             bus.clear_acc, bus.en_acc, bus.addr_x, bus.addr_f} !== 14'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got rx=%b rf=%b vy=%b wx=%b wf=%b clr=%b en=%b ax=%0d af=%0d, expected all 0",
                     bus.s_ready_x, bus.s_ready_f, bus.m_valid_y, bus.wr_en_x, bus.wr_en_f,
                     bus.clear_acc, bus.en_acc, bus.addr_x, bus.addr_f);
        end
        bus.s_valid_x = 1'b0;
        bus.s_valid_f = 1'b0;
        reset = 1'b0;
        #1;
        tests_run++;
        if ({bus.s_ready_x, bus.s_ready_f} !== 2'b11) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got rx=%b rf=%b, expected 1 1",
                     bus.s_ready_x, bus.s_ready_f);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic_frame();
        int exp_y [NY];
        exp_y = '{10, 14, 18, 22, 26};
        for (int i = 0; i < DATA_N; i++)   vx[i] = 8'(i + 1);
        for (int i = 0; i < FILTER_N; i++) vf[i] = 8'sd1;
        load_both();
        tests_run++;
        if (bus.clear_acc !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_clear_entry: got clear_acc=%b, expected 1", bus.clear_acc);
        end
        collect_frame(80);
        tests_run++;
        if (n_got !== NY) begin
            tests_failed++;
            $display("FAIL basic_count: got %0d results, expected %0d", n_got, NY);
        end
        for (int i = 0; i < n_got; i++) begin
            tests_run++;
            if (got_y[i] !== 21'(exp_y[i])) begin
                tests_failed++;
                $display("FAIL basic_y%0d: got %0d, expected %0d", i, got_y[i], exp_y[i]);
            end
        end
        tests_run++;
        if (got_t[0] !== FILTER_N + 1) begin
            tests_failed++;
            $display("FAIL basic_first_latency: got %0d cycles, expected %0d", got_t[0], FILTER_N + 1);
        end
        for (int i = 1; i < n_got; i++) begin
            tests_run++;
            if (got_t[i] - got_t[i-1] !== FILTER_N + 2) begin
                tests_failed++;
                $display("FAIL basic_period%0d: got %0d cycles, expected %0d",
                         i, got_t[i] - got_t[i-1], FILTER_N + 2);
            end
        end
        tests_run++;
        if ({bus.s_ready_x, bus.s_ready_f, bus.m_valid_y} !== 3'b110) begin
            tests_failed++;
            $display("FAIL basic_back_to_load: got rx=%b rf=%b vy=%b, expected 1 1 0",
                     bus.s_ready_x, bus.s_ready_f, bus.m_valid_y);
        end
    endtask

    task automatic test_second_frame();
        int exp_y [NY];
        exp_y = '{4, -4, 4, -4, 4};
        vx = '{-8'sd1, 8'sd2, -8'sd3, 8'sd4, -8'sd5, 8'sd6, -8'sd7, 8'sd8};
        for (int i = 0; i < FILTER_N; i++) vf[i] = 8'sd2;
        load_both();
        collect_frame(80);
        tests_run++;
        if (n_got !== NY) begin
            tests_failed++;
            $display("FAIL second_count: got %0d results, expected %0d", n_got, NY);
        end
        for (int i = 0; i < n_got; i++) begin
            tests_run++;
            if (got_y[i] !== 21'(exp_y[i])) begin
                tests_failed++;
                $display("FAIL second_y%0d: got %0d, expected %0d", i, got_y[i], exp_y[i]);
            end
        end
    endtask

    task automatic test_signed_extremes();
        for (int i = 0; i < DATA_N; i++)   vx[i] = -8'sd128;
        for (int i = 0; i < FILTER_N; i++) vf[i] = -8'sd128;
        load_both();
        collect_frame(80);
        tests_run++;
        if (n_got !== NY) begin
            tests_failed++;
            $display("FAIL ext_neg_count: got %0d results, expected %0d", n_got, NY);
        end
        for (int i = 0; i < n_got; i++) begin
            tests_run++;
            if (got_y[i] !== 21'sd65536) begin
                tests_failed++;
                $display("FAIL ext_negneg_y%0d: got %0d, expected 65536", i, got_y[i]);
            end
        end
        for (int i = 0; i < FILTER_N; i++) vf[i] = 8'sd127;
        load_both();
        collect_frame(80);
        tests_run++;
        if (n_got !== NY) begin
            tests_failed++;
            $display("FAIL ext_mix_count: got %0d results, expected %0d", n_got, NY);
        end
        for (int i = 0; i < n_got; i++) begin
            tests_run++;
            if (got_y[i] !== -21'sd65024) begin
                tests_failed++;
                $display("FAIL ext_negpos_y%0d: got %0d, expected -65024", i, got_y[i]);
            end
        end
    endtask

    task automatic test_staggered_load();
        int exp_y [NY];
        int fp = 0;
        int xp = 0;
        int cyc = 0;
        int bad_addr = 0;
        int stray_wr = 0;
        int ready_f_high = 0;
        logic ready_x_idle;
        exp_y = '{5, 7, 9, 11, 13};
        for (int i = 0; i < DATA_N; i++) vx[i] = 8'(i + 1);
        vf = '{8'sd1, -8'sd1, 8'sd2, 8'sd0};

        // Filter first, x idle.
        bus.s_valid_x = 1'b0;
        bus.s_valid_f = 1'b1;
        s_data_x = '0;
        ready_x_idle = 1'b0;
        while (fp < FILTER_N && cyc < 20) begin
            s_data_f = vf[fp];
            @(negedge clk);
            if (cyc == 0) ready_x_idle = bus.s_ready_x;
            if (bus.wr_en_x) stray_wr++;
            if (bus.wr_en_f) begin
                if (bus.addr_f !== 2'(fp)) bad_addr++;
                fp++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        tests_run++;
        if (ready_x_idle !== 1'b1) begin
            tests_failed++;
            $display("FAIL stag_ready_x_without_valid: got %b, expected 1", ready_x_idle);
        end

        // x toggling; f keeps offering a bogus tap that must be refused.
        s_data_f = 8'sd99;
        cyc = 0;
        while (xp < DATA_N && cyc < 40) begin
            bus.s_valid_x = (cyc % 2 == 0);
            s_data_x = vx[xp];
            @(negedge clk);
            if (bus.wr_en_f) stray_wr++;
            if (bus.s_ready_f) ready_f_high++;
            if (bus.wr_en_x) begin
                if (bus.addr_x !== 3'(xp)) bad_addr++;
                xp++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        tests_run++;
        if (bus.clear_acc !== 1'b1) begin
            tests_failed++;
            $display("FAIL stag_clear_entry: got clear_acc=%b, expected 1", bus.clear_acc);
        end
        bus.s_valid_x = 1'b0;
        bus.s_valid_f = 1'b0;

        tests_run++;
        if (xp !== DATA_N || fp !== FILTER_N) begin
            tests_failed++;
            $display("FAIL stag_pulses: got x=%0d f=%0d, expected x=%0d f=%0d", xp, fp, DATA_N, FILTER_N);
        end
        tests_run++;
        if (bad_addr !== 0 || stray_wr !== 0) begin
            tests_failed++;
            $display("FAIL stag_addr: got bad_addr=%0d stray_wr=%0d, expected 0 0", bad_addr, stray_wr);
        end
        tests_run++;
        if (ready_f_high !== 0) begin
            tests_failed++;
            $display("FAIL stag_ready_f_full: got %0d cycles high, expected 0", ready_f_high);
        end

        collect_frame(80);
        tests_run++;
        if (n_got !== NY) begin
            tests_failed++;
            $display("FAIL stag_count: got %0d results, expected %0d", n_got, NY);
        end
        for (int i = 0; i < n_got; i++) begin
            tests_run++;
            if (got_y[i] !== 21'(exp_y[i])) begin
                tests_failed++;
                $display("FAIL stag_y%0d: got %0d, expected %0d", i, got_y[i], exp_y[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int c;
        for (int i = 0; i < DATA_N; i++)   vx[i] = 8'(i + 1);
        for (int i = 0; i < FILTER_N; i++) vf[i] = 8'sd1;
        load_both();
        bus.m_ready_y = 1'b1;
        wait_valid(20, c);
        @(posedge clk); #1;                 // y[0] taken
        wait_valid(20, c);
        @(posedge clk); #1;                 // y[1] taken
        bus.m_ready_y = 1'b0;
        wait_valid(20, c);
        tests_run++;
        if (bus.m_valid_y !== 1'b1 || acc !== 21'sd18) begin
            tests_failed++;
            $display("FAIL bp_y2: got valid=%b y=%0d, expected valid=1 y=18", bus.m_valid_y, acc);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.m_valid_y !== 1'b1 || acc !== 21'sd18) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: got valid=%b y=%0d, expected valid=1 y=18", i, bus.m_valid_y, acc);
            end
            tests_run++;
            if ({bus.en_acc, bus.clear_acc} !== 2'b00) begin
                tests_failed++;
                $display("FAIL bp_enables%0d: got en=%b clr=%b, expected 0 0", i, bus.en_acc, bus.clear_acc);
            end
            @(posedge clk); #1;
        end
        bus.m_ready_y = 1'b1;
        @(posedge clk); #1;                 // y[2] taken
        bus.m_ready_y = 1'b0;
        wait_valid(20, c);
        tests_run++;
        if (1 + c !== FILTER_N + 2 || bus.m_valid_y !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release_latency: got %0d cycles valid=%b, expected %0d valid=1",
                     1 + c, bus.m_valid_y, FILTER_N + 2);
        end
        tests_run++;
        if (acc !== 21'sd22) begin
            tests_failed++;
            $display("FAIL bp_y3: got %0d, expected 22", acc);
        end
        bus.m_ready_y = 1'b1;
        @(posedge clk); #1;                 // y[3] taken
        wait_valid(20, c);
        tests_run++;
        if (bus.m_valid_y !== 1'b1 || acc !== 21'sd26) begin
            tests_failed++;
            $display("FAIL bp_y4: got valid=%b y=%0d, expected valid=1 y=26", bus.m_valid_y, acc);
        end
        @(posedge clk); #1;                 // y[4] taken, back to LOAD
        bus.m_ready_y = 1'b0;
    endtask

    task automatic test_reset_mid_mac();
        int c;
        for (int i = 0; i < DATA_N; i++)   vx[i] = 8'(i + 1);
        for (int i = 0; i < FILTER_N; i++) vf[i] = 8'sd1;
        load_both();
        bus.m_ready_y = 1'b1;
        wait_valid(20, c);
        @(posedge clk); #1;                 // y[0] taken, now CLEAR for y[1]
        bus.m_ready_y = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;             // MAC k=0, 1, 2
        end
        tests_run++;
        if ({bus.en_acc, bus.addr_x, bus.addr_f} !== {1'b1, 3'd3, 2'd2}) begin
            tests_failed++;
            $display("FAIL rst_mac_k2: got en=%b ax=%0d af=%0d, expected en=1 ax=3 af=2",
                     bus.en_acc, bus.addr_x, bus.addr_f);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        bus.s_valid_x = 1'b1;
        bus.s_valid_f = 1'b1;
        #1;
        tests_run++;
        if ({bus.s_ready_x, bus.s_ready_f, bus.m_valid_y, bus.wr_en_x, bus.wr_en_f,
             bus.clear_acc, bus.en_acc, bus.addr_x, bus.addr_f} !== 14'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_outputs: got rx=%b rf=%b vy=%b wx=%b wf=%b clr=%b en=%b ax=%0d af=%0d, expected all 0",
                     bus.s_ready_x, bus.s_ready_f, bus.m_valid_y, bus.wr_en_x, bus.wr_en_f,
                     bus.clear_acc, bus.en_acc, bus.addr_x, bus.addr_f);
        end
        bus.s_valid_x = 1'b0;
        bus.s_valid_f = 1'b0;
        reset = 1'b0;
        #1;
        tests_run++;
        if ({bus.s_ready_x, bus.s_ready_f} !== 2'b11) begin
            tests_failed++;
            $display("FAIL rst_mid_ready: got rx=%b rf=%b, expected 1 1", bus.s_ready_x, bus.s_ready_f);
        end
        for (int i = 0; i < DATA_N; i++) vx[i] = 8'(DATA_N - i);
        vf = '{8'sd1, 8'sd0, 8'sd0, -8'sd1};
        load_both();
        collect_frame(80);
        tests_run++;
        if (n_got !== NY) begin
            tests_failed++;
            $display("FAIL rst_reload_count: got %0d results, expected %0d", n_got, NY);
        end
        for (int i = 0; i < n_got; i++) begin
            tests_run++;
            if (got_y[i] !== 21'sd3) begin
                tests_failed++;
                $display("FAIL rst_reload_y%0d: got %0d, expected 3", i, got_y[i]);
            end
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        for (int i = 0; i < DATA_N; i++)   x_mem[i] = '0;
        for (int i = 0; i < FILTER_N; i++) f_mem[i] = '0;
        bus.s_valid_x = 1'b0;
        bus.s_valid_f = 1'b0;
        bus.m_ready_y = 1'b0;
        s_data_x = '0;
        s_data_f = '0;

        test_reset();
        test_basic_frame();
        test_second_frame();
        test_signed_extremes();
        test_staggered_load();
        test_backpressure();
        test_reset_mid_mac();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 time units, expected the sequence to finish");
        $fatal(1, "watchdog expired");
    end

endmodule
